// File: rtl/sudoku_ram_arbiter_if.sv
// Board-RAM arbitration bus: controller and checker request channels plus the shared sync-RAM port.
// The arbiter takes the slave view; requesters and the RAM together form the master side.
interface sudoku_ram_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 16
);
    logic              ctl_req;
    logic              ctl_we;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_gnt;
    logic              ctl_rvalid;
    logic [DATA_W-1:0] ctl_rdata;

    logic              chk_req;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_gnt;
    logic              chk_rvalid;
    logic [DATA_W-1:0] chk_rdata;
    logic              chk_restart;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  ctl_req, ctl_we, ctl_addr, ctl_wdata,
        input  chk_req, chk_addr,
        input  ram_q,
        output ctl_gnt, ctl_rvalid, ctl_rdata,
        output chk_gnt, chk_rvalid, chk_rdata, chk_restart,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output ctl_req, ctl_we, ctl_addr, ctl_wdata,
        output chk_req, chk_addr,
        output ram_q,
        input  ctl_gnt, ctl_rvalid, ctl_rdata,
        input  chk_gnt, chk_rvalid, chk_rdata, chk_restart,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/sudoku_ram_arbiter.sv
// Two-requester arbiter for the single board-RAM port: controller has priority, checker is
// protected from starvation, and sync-read data is steered back to whoever issued the read.
module sudoku_ram_arbiter #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    sudoku_ram_arbiter_if.slave  bus
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic {
        OWN_CTL = 1'b0,
        OWN_CHK = 1'b1
    } owner_e;

    typedef struct packed {
        logic   rd;
        owner_e owner;
    } tag_t;

    logic              r_ctl_gnt;
    logic              r_chk_gnt;
    logic              r_restart;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    tag_t              r_tag1;
    tag_t              r_tag2;
    logic              r_ctl_rvalid;
    logic              r_chk_rvalid;
    logic [DATA_W-1:0] r_ctl_rdata;
    logic [DATA_W-1:0] r_chk_rdata;

    logic              w_ctl_elig;
    logic              w_chk_elig;
    logic              w_starved;
    logic              w_ctl_win;
    logic              w_chk_win;
    tag_t              w_tag_issue;
    logic [CNT_W-1:0]  w_cnt_next;

    // A requester whose grant is showing this cycle sits out one edge, so a held req
    // cannot be double-issued before the requester has had a chance to react.
    always_comb begin
        w_ctl_elig = bus.ctl_req & ~r_ctl_gnt;
        w_chk_elig = bus.chk_req & ~r_chk_gnt;
        w_starved  = (r_starve_cnt == CNT_W'(STARVE_MAX));
        w_chk_win  = w_chk_elig & (~w_ctl_elig | w_starved);
        w_ctl_win  = w_ctl_elig & ~w_chk_win;
    end

    always_comb begin
        w_tag_issue.rd    = w_chk_win | (w_ctl_win & ~bus.ctl_we);
        w_tag_issue.owner = w_chk_win ? OWN_CHK : OWN_CTL;

        w_cnt_next = r_starve_cnt;
        if (!bus.chk_req || w_chk_win) begin
            w_cnt_next = '0;
        end else if (w_ctl_win && !w_starved) begin
            w_cnt_next = r_starve_cnt + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctl_gnt    <= 1'b0;
            r_chk_gnt    <= 1'b0;
            r_restart    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_ctl_gnt    <= w_ctl_win;
            r_chk_gnt    <= w_chk_win;
            r_restart    <= w_ctl_win & bus.ctl_we;
            r_ram_we     <= w_ctl_win & bus.ctl_we;
            r_starve_cnt <= w_cnt_next;
            if (w_ctl_win) begin
                r_ram_addr  <= bus.ctl_addr;
                r_ram_wdata <= bus.ctl_wdata;
            end else if (w_chk_win) begin
                r_ram_addr  <= bus.chk_addr;
            end
        end
    end

    // Tag stage 1 lines up with the command on the RAM pins, stage 2 with ram_q;
    // clearing the tags on reset drops any read still in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tag1       <= '0;
            r_tag2       <= '0;
            r_ctl_rvalid <= 1'b0;
            r_chk_rvalid <= 1'b0;
            r_ctl_rdata  <= '0;
            r_chk_rdata  <= '0;
        end else begin
            r_tag1       <= w_tag_issue;
            r_tag2       <= r_tag1;
            r_ctl_rvalid <= r_tag2.rd & (r_tag2.owner == OWN_CTL);
            r_chk_rvalid <= r_tag2.rd & (r_tag2.owner == OWN_CHK);
            if (r_tag2.rd && r_tag2.owner == OWN_CTL) begin
                r_ctl_rdata <= bus.ram_q;
            end
            if (r_tag2.rd && r_tag2.owner == OWN_CHK) begin
                r_chk_rdata <= bus.ram_q;
            end
        end
    end

    assign bus.ctl_gnt     = r_ctl_gnt;
    assign bus.chk_gnt     = r_chk_gnt;
    assign bus.chk_restart = r_restart;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.ctl_rvalid  = r_ctl_rvalid;
    assign bus.chk_rvalid  = r_chk_rvalid;
    assign bus.ctl_rdata   = r_ctl_rdata;
    assign bus.chk_rdata   = r_chk_rdata;
endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Bench for sudoku_ram_arbiter: hand vectors, a checker scan, a mid-read reset and random traffic,
// all compared each cycle against a queue-based model of the arbitration and read-return rules.
module tb_sudoku_ram_arbiter;
    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;
    localparam logic [DATA_W-1:0] ROW_INIT [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ram_init = 1'b1;
    always #5 CLK = ~CLK;

    sudoku_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sudoku_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Behavioural sync RAM: data for the address presented in a cycle appears in the next one.
    logic [DATA_W-1:0] ram [4];
    logic [DATA_W-1:0] ram_q_r;
    always @(posedge CLK) begin
        if (ram_init) begin
            for (int i = 0; i < 4; i++) ram[i] <= ROW_INIT[i];
        end else if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
        ram_q_r <= ram[bus.ram_addr];
    end
    assign bus.ram_q = ram_q_r;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: reads are queued with the board contents at issue time and retire
    // two cycles after their grant; a granted write lands in the board one cycle later.
    typedef struct {
        logic              to_chk;
        logic [DATA_W-1:0] data;
        int                rem;
    } rd_t;

    rd_t               pend[$];
    logic [DATA_W-1:0] m_mem [4];
    logic              m_ctl_gnt, m_chk_gnt, m_restart, m_ram_we, m_ctl_rvalid, m_chk_rvalid;
    logic [ADDR_W-1:0] m_ram_addr;
    logic [DATA_W-1:0] m_ram_wdata, m_ctl_rdata, m_chk_rdata;
    int                m_cnt;

    task automatic model_reset();
        pend.delete();
        {m_ctl_gnt, m_chk_gnt, m_restart, m_ram_we, m_ctl_rvalid, m_chk_rvalid} = '0;
        m_ram_addr  = '0;
        m_ram_wdata = '0;
        m_ctl_rdata = '0;
        m_chk_rdata = '0;
        m_cnt       = 0;
    endtask

    task automatic model_step();
        bit  ce, he, cw, hw;
        rd_t r;
        if (m_ram_we) m_mem[m_ram_addr] = m_ram_wdata;
        ce = bus.ctl_req && !m_ctl_gnt;
        he = bus.chk_req && !m_chk_gnt;
        hw = he && (!ce || m_cnt == STARVE_MAX);
        cw = ce && !hw;
        m_ctl_rvalid = 1'b0;
        m_chk_rvalid = 1'b0;
        foreach (pend[i]) pend[i].rem--;
        while (pend.size() > 0 && pend[0].rem == 0) begin
            r = pend.pop_front();
            if (r.to_chk) begin
                m_chk_rvalid = 1'b1;
                m_chk_rdata  = r.data;
            end else begin
                m_ctl_rvalid = 1'b1;
                m_ctl_rdata  = r.data;
            end
        end
        if (!bus.chk_req || hw) m_cnt = 0;
        else if (cw && m_cnt < STARVE_MAX) m_cnt++;
        m_ctl_gnt = cw;
        m_chk_gnt = hw;
        m_restart = cw && bus.ctl_we;
        m_ram_we  = cw && bus.ctl_we;
        if (cw) begin
            m_ram_addr  = bus.ctl_addr;
            m_ram_wdata = bus.ctl_wdata;
            if (!bus.ctl_we) pend.push_back('{1'b0, m_mem[bus.ctl_addr], 2});
        end else if (hw) begin
            m_ram_addr = bus.chk_addr;
            pend.push_back('{1'b1, m_mem[bus.chk_addr], 2});
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_ctl_gnt"},    bus.ctl_gnt,     m_ctl_gnt);
        check({tag, "_chk_gnt"},    bus.chk_gnt,     m_chk_gnt);
        check({tag, "_restart"},    bus.chk_restart, m_restart);
        check({tag, "_ram_we"},     bus.ram_we,      m_ram_we);
        check({tag, "_ram_addr"},   bus.ram_addr,    m_ram_addr);
        check({tag, "_ram_wdata"},  bus.ram_wdata,   m_ram_wdata);
        check({tag, "_ctl_rvalid"}, bus.ctl_rvalid,  m_ctl_rvalid);
        check({tag, "_chk_rvalid"}, bus.chk_rvalid,  m_chk_rvalid);
        check({tag, "_ctl_rdata"},  bus.ctl_rdata,   m_ctl_rdata);
        check({tag, "_chk_rdata"},  bus.chk_rdata,   m_chk_rdata);
    endtask

    // Inputs are set in the low phase; outputs are compared at the following falling edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        bus.ctl_req   = 1'b0;
        bus.ctl_we    = 1'b0;
        bus.ctl_addr  = '0;
        bus.ctl_wdata = '0;
        bus.chk_req   = 1'b0;
        bus.chk_addr  = '0;
    endtask

    typedef struct {
        logic              cr, cw;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        logic              hr;
        logic [ADDR_W-1:0] ha;
        logic              e_cg, e_hg, e_rs, e_we, e_cv, e_hv;
        logic [DATA_W-1:0] e_crd, e_hrd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Write row 2, read it back, interleaved reads, then a write racing a checker read of row 1.
        tbl[0]  = '{1, 1, 2, 16'h1234, 0, 0,  1, 0, 1, 1, 0, 0, 16'h0000, 16'h4444};
        tbl[1]  = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0000, 16'h4444};
        tbl[2]  = '{1, 0, 2, 16'h0000, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0000, 16'h4444};
        tbl[3]  = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0000, 16'h4444};
        tbl[4]  = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 1, 0, 16'h1234, 16'h4444};
        tbl[5]  = '{1, 0, 0, 16'h0000, 1, 3,  1, 0, 0, 0, 0, 0, 16'h1234, 16'h4444};
        tbl[6]  = '{0, 0, 0, 16'h0000, 1, 3,  0, 1, 0, 0, 0, 0, 16'h1234, 16'h4444};
        tbl[7]  = '{1, 0, 1, 16'h0000, 0, 0,  1, 0, 0, 0, 1, 0, 16'h1111, 16'h4444};
        tbl[8]  = '{0, 0, 0, 16'h0000, 1, 2,  0, 1, 0, 0, 0, 1, 16'h1111, 16'h4444};
        tbl[9]  = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 1, 0, 16'h2222, 16'h4444};
        tbl[10] = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 1, 16'h2222, 16'h1234};
        tbl[11] = '{1, 1, 1, 16'hBEEF, 1, 1,  1, 0, 1, 1, 0, 0, 16'h2222, 16'h1234};
        tbl[12] = '{0, 0, 0, 16'h0000, 1, 1,  0, 1, 0, 0, 0, 0, 16'h2222, 16'h1234};
        tbl[13] = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 0, 16'h2222, 16'h1234};
        tbl[14] = '{0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0, 0, 1, 16'h2222, 16'hBEEF};

        for (int i = 0; i < 4; i++) m_mem[i] = ROW_INIT[i];
        idle_inputs();
        model_reset();

        // Power-on reset.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        ram_init = 1'b0;
        RST      = 1'b0;
        compare_model("por");

        // Checker read in flight plus a controller write on the pins, then reset mid-cycle.
        bus.chk_req = 1'b1; bus.chk_addr = 2'd3;
        cycle("pre_rst_chk");
        bus.chk_req = 1'b0;
        bus.ctl_req = 1'b1; bus.ctl_we = 1'b1; bus.ctl_addr = 2'd0; bus.ctl_wdata = 16'hDEAD;
        cycle("pre_rst_wr");
        idle_inputs();
        #2 RST = 1'b1;
        #1;
        check("rst_ram_we",     bus.ram_we,      1'b0);
        check("rst_ram_addr",   bus.ram_addr,    2'd0);
        check("rst_ram_wdata",  bus.ram_wdata,   16'h0000);
        check("rst_ctl_gnt",    bus.ctl_gnt,     1'b0);
        check("rst_chk_restart", bus.chk_restart, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) cycle("post_rst");

        // Checker scan alone: row k requested until its grant, one grant every other cycle.
        for (int i = 0; i < 10; i++) begin
            bus.chk_req  = (i < 8);
            bus.chk_addr = ADDR_W'(i / 2);
            cycle("scan");
            check($sformatf("scan%0d_gnt", i), bus.chk_gnt, (i < 8) && (i % 2 == 0));
            check($sformatf("scan%0d_we", i),  bus.ram_we,  1'b0);
            if (i >= 2 && i % 2 == 0) begin
                check($sformatf("scan%0d_rvalid", i), bus.chk_rvalid, 1'b1);
                check($sformatf("scan%0d_rdata", i),  bus.chk_rdata,  ROW_INIT[(i - 2) / 2]);
            end
        end

        // Hand-written vector table.
        for (int i = 0; i < 15; i++) begin
            bus.ctl_req = tbl[i].cr; bus.ctl_we = tbl[i].cw;
            bus.ctl_addr = tbl[i].ca; bus.ctl_wdata = tbl[i].cd;
            bus.chk_req = tbl[i].hr; bus.chk_addr = tbl[i].ha;
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ctl_gnt", i),    bus.ctl_gnt,     tbl[i].e_cg);
            check($sformatf("vec%0d_chk_gnt", i),    bus.chk_gnt,     tbl[i].e_hg);
            check($sformatf("vec%0d_restart", i),    bus.chk_restart, tbl[i].e_rs);
            check($sformatf("vec%0d_ram_we", i),     bus.ram_we,      tbl[i].e_we);
            check($sformatf("vec%0d_ctl_rvalid", i), bus.ctl_rvalid,  tbl[i].e_cv);
            check($sformatf("vec%0d_chk_rvalid", i), bus.chk_rvalid,  tbl[i].e_hv);
            check($sformatf("vec%0d_ctl_rdata", i),  bus.ctl_rdata,   tbl[i].e_crd);
            check($sformatf("vec%0d_chk_rdata", i),  bus.chk_rdata,   tbl[i].e_hrd);
        end

        // Sustained contention with both requests held high.
        idle_inputs();
        bus.ctl_req = 1'b1; bus.ctl_addr = 2'd3;
        bus.chk_req = 1'b1; bus.chk_addr = 2'd0;
        for (int i = 0; i < 12; i++) cycle("hold");
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("drain");

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.ctl_req   = ($urandom_range(0, 2) != 0);
            bus.ctl_we    = ($urandom_range(0, 3) == 0);
            bus.ctl_addr  = ADDR_W'($urandom_range(0, 3));
            bus.ctl_wdata = DATA_W'($urandom);
            bus.chk_req   = ($urandom_range(0, 2) != 0);
            bus.chk_addr  = ADDR_W'($urandom_range(0, 3));
            cycle("rand");
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
